// File: rtl/spi_ctrl_pkg.sv
// Shared types and widths for the SPI link controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ARMED, XFER, DONE} ctrl_state_t;

  localparam int unsigned SPI_DATA_W = 18;
  localparam int unsigned SPI_CMD_W  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [IdxW-1:0] cand;

  // Scan (ptr+1) .. (ptr+N) mod N and keep the first asserted request.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IdxW'((32'(ptr) + i) % N);
      if (!gnt_any && req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_link_ctrl.sv
// Sequencer sharing the SPI slave transmit word among several requesters.
// Transfer end is the rising edge of spi_status seen in XFER, since the
// slave's rx_valid is sticky.
module spi_link_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = SPI_DATA_W,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  input  logic                    spi_status,
  input  logic [SPI_CMD_W-1:0]    spi_rx_data,
  output logic [DATA_W-1:0]       spi_tx_data,
  output logic                    spi_load,
  output logic [SPI_CMD_W-1:0]    cmd_data,
  output logic                    cmd_valid,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  ctrl_state_t          state_q, state_d;
  logic [IdxW-1:0]      idx_q, ptr_q, win_idx;
  logic                 win_any;
  logic [DATA_W-1:0]    tx_data_q;
  logic [SPI_CMD_W-1:0] cmd_data_q;
  logic                 timeout_err_q;
  logic [CntW-1:0]      cnt_q;
  logic                 tmo_hit;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (win_idx),
    .gnt_any (win_any)
  );

  // A status rise on the last counted cycle wins over the timeout.
  assign tmo_hit = (state_q == XFER) && !spi_status && (cnt_q == CntW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any && spi_status) state_d = LOAD;
      LOAD:    state_d = ARMED;
      ARMED:   if (!spi_status) state_d = XFER;
      XFER: begin
        if (spi_status)   state_d = DONE;
        else if (tmo_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe outputs decoded from the current state.
  always_comb begin
    grant     = '0;
    done      = '0;
    spi_load  = 1'b0;
    cmd_valid = 1'b0;
    case (state_q)
      LOAD: begin
        spi_load     = 1'b1;
        grant[idx_q] = 1'b1;
      end
      XFER: if (tmo_hit) done[idx_q] = 1'b1;
      DONE: begin
        cmd_valid   = 1'b1;
        done[idx_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: winner latch, transfer counter, command capture, pointer, sticky error.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      idx_q         <= '0;
      ptr_q         <= IdxW'(N_REQ - 1);
      tx_data_q     <= '0;
      cmd_data_q    <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      if (state_q == IDLE && state_d == LOAD) begin
        idx_q     <= win_idx;
        tx_data_q <= req_data[win_idx*DATA_W +: DATA_W];
      end
      cnt_q <= (state_q == XFER) ? cnt_q + 1'b1 : '0;
      // Capture on the closing edge so cmd_data is valid alongside cmd_valid.
      if (state_q == XFER && spi_status) cmd_data_q <= spi_rx_data;
      if (tmo_hit) timeout_err_q <= 1'b1;
      if (state_q == DONE || tmo_hit) ptr_q <= idx_q;
    end
  end

  assign spi_tx_data = tx_data_q;
  assign cmd_data    = cmd_data_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_link_ctrl.sv
// Directed bench for spi_link_ctrl with a transaction scoreboard.
module tb_spi_link_ctrl;

  localparam int NREQ = 4;
  localparam int DW   = 18;
  localparam int TMO  = 16;

  logic             sys_clk;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             spi_status;
  logic [7:0]       spi_rx_data;
  logic [DW-1:0]    spi_tx_data;
  logic             spi_load;
  logic [7:0]       cmd_data;
  logic             cmd_valid;
  logic             busy;
  logic             timeout_err;

  logic [DW-1:0] words [NREQ];
  assign req_data = {words[3], words[2], words[1], words[0]};

  spi_link_ctrl #(
    .N_REQ   (NREQ),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .spi_status  (spi_status),
    .spi_rx_data (spi_rx_data),
    .spi_tx_data (spi_tx_data),
    .spi_load    (spi_load),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // mode: 0 normal close, 1 close on the exact timeout cycle, 2 abandoned
  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    logic [7:0]  cmd;
    int          mode;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   load_wait = 0;
  bit   exp_tmo = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] cmd, input int mode);
    exp_t e;
    e.idx  = idx;
    e.data = words[idx];
    e.cmd  = cmd;
    e.mode = mode;
    sb.push_back(e);
  endtask

  task automatic no_load(input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(negedge sys_clk);
      if (spi_load || busy) seen = 1'b1;
    end
    check("no_load_while_slave_busy", 32'(seen), 32'd0);
  endtask

  // One full transaction; low = cycles spi_status stays low in mode 0.
  task automatic run_txn(input int low, input bit drop_req);
    exp_t e;
    bit   found;
    int   n;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    found = 1'b0;
    load_wait = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (spi_load) begin
        found = 1'b1;
        load_wait = i + 1;
        break;
      end
    end
    check("load_seen", 32'(found), 32'd1);
    check("grant", 32'(grant), 32'd1 << e.idx);
    check("tx_data", 32'(spi_tx_data), 32'(e.data));
    check("busy_in_load", 32'(busy), 32'd1);
    @(posedge sys_clk); #1;
    spi_status  = 1'b0;
    spi_rx_data = e.cmd;
    if (e.mode == 0) begin
      repeat (low) @(posedge sys_clk);
      #1 spi_status = 1'b1;
    end else if (e.mode == 1) begin
      repeat (TMO) @(posedge sys_clk);
      #1 spi_status = 1'b1;
    end
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      n++;
      if (|done) begin
        found = 1'b1;
        break;
      end
    end
    if (drop_req) req = '0;
    if (e.mode == 2) exp_tmo = 1'b1;
    check("done_seen", 32'(found), 32'd1);
    check("done", 32'(done), 32'd1 << e.idx);
    check("cmd_valid", 32'(cmd_valid), 32'(e.mode != 2));
    if (e.mode != 2) check("cmd_data", 32'(cmd_data), 32'(e.cmd));
    if (e.mode == 1) check("race_latency", n, 32'd2);
    if (e.mode == 2) check("timeout_latency", n, 32'(TMO + 1));
    @(negedge sys_clk);
    check("done_single_cycle", 32'(done | {NREQ{cmd_valid}}), 32'd0);
    check("timeout_err", 32'(timeout_err), 32'(exp_tmo));
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    bit bad;
    words[0] = 18'h00011;
    words[1] = 18'h10F22;
    words[2] = 18'h2A5C3;
    words[3] = 18'h3C0DE;
    rst_n       = 1'b0;
    req         = '0;
    spi_status  = 1'b1;
    spi_rx_data = '0;

    // Reset values.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_data", 32'(spi_tx_data), 32'd0);
    check("rst_load", 32'(spi_load), 32'd0);
    check("rst_cmd_data", 32'(cmd_data), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;

    // Round-robin with all requesters held.
    @(posedge sys_clk); #1;
    req = 4'b1111;
    push(0, 8'hA0, 0);
    push(1, 8'hA1, 0);
    push(2, 8'hA2, 0);
    push(3, 8'hA3, 0);
    push(0, 8'hA4, 0);
    for (int k = 0; k < 5; k++) run_txn(4, k == 4);

    // Single request.
    @(posedge sys_clk); #1;
    req = 4'b0100;
    push(2, 8'h7E, 0);
    run_txn(12, 1'b1);
    check("single_load_latency", load_wait, 32'd2);

    // Slave busy when the request arrives.
    @(posedge sys_clk); #1;
    spi_status = 1'b0;
    req = 4'b0001;
    push(0, 8'h5A, 0);
    no_load(6);
    @(posedge sys_clk); #1;
    spi_status = 1'b1;
    run_txn(5, 1'b1);
    check("busy_release_latency", load_wait, 32'd2);

    // Status rise on the exact timeout cycle.
    @(posedge sys_clk); #1;
    req = 4'b0010;
    push(1, 8'h3C, 1);
    run_txn(0, 1'b1);

    // Timeout, then no load until the slave returns to idle.
    @(posedge sys_clk); #1;
    req = 4'b1000;
    push(3, 8'h99, 2);
    run_txn(0, 1'b1);
    @(posedge sys_clk); #1;
    req = 4'b0001;
    push(0, 8'h11, 0);
    no_load(6);
    @(posedge sys_clk); #1;
    spi_status = 1'b1;
    run_txn(4, 1'b1);
    check("post_timeout_load_latency", load_wait, 32'd2);

    // Reset in the middle of a transfer.
    @(posedge sys_clk); #1;
    req = 4'b0100;
    bad = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (spi_load) begin
        bad = 1'b0;
        break;
      end
    end
    check("midrst_load_seen", 32'(bad), 32'd0);
    @(posedge sys_clk); #1;
    spi_status = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    req = '0;
    exp_tmo = 1'b0;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_tx_data", 32'(spi_tx_data), 32'd0);
    check("midrst_load", 32'(spi_load), 32'd0);
    check("midrst_cmd_data", 32'(cmd_data), 32'd0);
    check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge sys_clk);
      if ((|done) || busy) bad = 1'b1;
    end
    check("midrst_no_done", 32'(bad), 32'd0);
    @(posedge sys_clk); #1;
    spi_status = 1'b1;
    req = 4'b1111;
    push(0, 8'h42, 0);
    run_txn(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_link_ctrl.md
# spi_link_ctrl

Transaction sequencer for the `sys_clk`-domain side of the SPI slave. It shares the slave's 18-bit transmit word among `N_REQ` requesters using round-robin arbitration, and loads the granted word while the slave is idle. It then tracks the master-driven transfer through the slave's `status` line and captures the received command byte when the transaction closes. It sits between game/status logic and the SPI slave and is the only block that drives the slave's `tx_data`/`load`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `DATA_W`, default 18: transmit word width; must match the slave.
- `TIMEOUT`, default 4096: maximum `sys_clk` cycles a transfer may stay active before it is abandoned.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  N_REQ  per-requester request level; held high until its `done` pulse.
- `req_data`  in  N_REQ*DATA_W  packed words; requester i occupies `[i*DATA_W +: DATA_W]`.
- `grant`  out  N_REQ  one-hot, single-cycle pulse when the requester's word is loaded.
- `done`  out  N_REQ  one-hot, single-cycle pulse when that requester's transfer completes or is abandoned.
- `spi_status`  in  1  slave `status`: 1 = idle, 0 = chip-select active.
- `spi_rx_data`  in  8  slave `rx_data`.
- `spi_tx_data`  out  DATA_W  word presented to the slave.
- `spi_load`  out  1  single-cycle load strobe to the slave.
- `cmd_data`  out  8  last captured command byte.
- `cmd_valid`  out  1  single-cycle pulse when `cmd_data` updates.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `timeout_err`  out  1  sticky; set when a transfer is abandoned, cleared only by reset.

## Operation
The slave's `rx_valid` is sticky and unusable as a per-transfer strobe. The end of a transaction is therefore defined solely as the rising edge of `spi_status` seen in XFER.

FSM states:
- **IDLE**
  - If `|req && spi_status`: latch the round-robin winner's index and word, then go to LOAD.
  - If no request is pending, or `spi_status` is 0: stay in IDLE.
- **LOAD**
  - Drive `spi_load=1` and `grant[idx]=1` for exactly one cycle.
  - `spi_tx_data` holds the latched word; it is a register, stable from LOAD until the next LOAD.
  - Next state is ARMED.
- **ARMED**
  - Wait for `spi_status==0`, then go to XFER.
  - There is no timeout here; the master may take arbitrarily long to start.
- **XFER**
  - Count cycles while in this state.
  - On `spi_status==1`, go to DONE.
  - On count reaching `TIMEOUT-1` with `spi_status` still 0: set `timeout_err`, pulse `done[idx]`, do not pulse `cmd_valid`, and go to IDLE. IDLE then naturally waits for `spi_status==1` before any new load.
- **DONE**
  - `cmd_data <= spi_rx_data`, `cmd_valid=1`, `done[idx]=1`, all for one cycle.
  - Advance the priority pointer to `idx`.
  - Next state is IDLE.

Arbitration:
- Round-robin starting at `(ptr+1) mod N_REQ`.
- Reset value of `ptr` is `N_REQ-1`, so requester 0 wins first.
- The pointer advances only on completion (DONE or timeout), never on a bare grant.

Request rules:
- A requester dropping `req` before its grant is ignored.
- Dropping `req` after grant is illegal, but the transfer still completes normally.
- `req_data` is sampled only in the IDLE→LOAD cycle.

## Timing
- Reset values: `grant=0`, `done=0`, `spi_tx_data=0`, `spi_load=0`, `cmd_data=0`, `cmd_valid=0`, `busy=0`, `timeout_err=0`, state IDLE.
- `rst_n` low in any state returns every register to its reset value on the next edge; a mid-transfer reset gives no `done` pulse.
- Request in IDLE at edge t (with `spi_status=1`): `spi_load` and `grant` are high during cycle t+1.
- `spi_status` rising at edge t in XFER: `cmd_valid`/`done` are high during cycle t+1.
- `spi_status` dropping during LOAD is tolerated; ARMED sees it the next cycle.
- Simultaneous `spi_status` rise and timeout count in XFER: the rise wins and the transfer ends normally.
- Minimum back-to-back transaction cost is 5 cycles plus the slave transfer.

## Structure
- Package `spi_ctrl_pkg`:
  - `typedef enum logic [2:0] {IDLE, LOAD, ARMED, XFER, DONE} ctrl_state_t`
  - `localparam SPI_DATA_W = 18`
  - `localparam SPI_CMD_W = 8`
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req[N]`, `ptr`.
  - Outputs `gnt_idx`, `gnt_any`.
  - Purely combinational.
- All state lives in `spi_link_ctrl`.

## Test plan
- **Single request:** `N_REQ=4`, `req=4'b0100`, `req_data[2]=18'h2A5C3`. Expect `spi_load`+`grant=4'b0100` one cycle later with `spi_tx_data=18'h2A5C3`. Drop `spi_status` for 20 cycles with `spi_rx_data=8'h7E`. Expect `cmd_data=8'h7E`, `cmd_valid` and `done=4'b0100` one cycle after the rise.
- **Round-robin:** hold `req=4'b1111` across 5 transactions. Expect grant order 0,1,2,3,0.
- **Slave busy at request:** `spi_status=0` while `req=4'b0001`. Expect no `spi_load` until the cycle after `spi_status` returns to 1.
- **Timeout:** `TIMEOUT=16`, hold `spi_status=0` after load. Expect `done` pulse 16 cycles into XFER, `timeout_err=1`, no `cmd_valid`, and no new load until `spi_status=1`.
- **Race at timeout:** `spi_status` rises on the exact timeout cycle. Expect `cmd_valid=1` and `timeout_err` to stay 0.
- **Reset mid-XFER:** assert `rst_n=0` for 1 cycle. Expect all outputs at reset values, state IDLE, and the next grant goes to requester 0.
